rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3: number of ordered reset stages; 1..8.
REQ-002 SHALL have parameter STAGE_DLY, default 1024: clk cycles between successive stage releases; 1..65535.
REQ-003 SHALL have parameter LOCK_FILT, default 16: consecutive clk cycles locked must be high before sequencing starts; 1..255.
REQ-004 SHALL have parameter INIT_TMO, default 65535: clk cycles allowed for init_done after init_start; 1..65535.
REQ-005 SHALL have port clk, input, 1: sequencer clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port locked, input, 1: PLL lock, already synchronous to clk.
REQ-008 SHALL have port init_done, input, 1: downstream (SDRAM controller) initialisation complete, level.
REQ-009 SHALL have port sw_req, input, 1: single-cycle software reset request.
REQ-010 SHALL have port rst_stage, output, NSTAGE: per-stage reset, active-high; bit 0 released first.
REQ-011 SHALL have port init_start, output, 1: single-cycle pulse starting downstream initialisation.
REQ-012 SHALL have port ready, output, 1: sequence complete, system active.
REQ-013 SHALL have port fault, output, 1: init timeout occurred.
REQ-014 SHALL have port state, output, 3: current FSM encoding, for debug.

Function
REQ-015 FSM states SHALL be: INIT=0, LOCK_WAIT=1, RELEASE=2, INIT_WAIT=3, ACTIVE=4, FAULT=5.
REQ-016 INIT SHALL go to LOCK_WAIT after one cycle and clear all counters.
REQ-017 LOCK_WAIT SHALL count consecutive locked-high cycles, zero the count on any locked-low cycle, and go to RELEASE on the cycle the count reaches LOCK_FILT.
REQ-018 RELEASE SHALL deassert rst_stage[i] STAGE_DLY cycles after rst_stage[i-1] deasserts; rst_stage[0] deasserts STAGE_DLY cycles after RELEASE entry.
REQ-019 The last stage release SHALL move the FSM to INIT_WAIT and pulse init_start for exactly one cycle on INIT_WAIT entry.
REQ-020 INIT_WAIT SHALL go to ACTIVE on the first cycle init_done is high; ready SHALL assert the cycle after.
REQ-021 In RELEASE, INIT_WAIT or ACTIVE, locked low for one cycle SHALL reassert all rst_stage bits and clear ready on the next edge, then enter LOCK_WAIT.
REQ-022 sw_req in any state except INIT SHALL reassert all rst_stage bits, clear ready and fault, and enter INIT on the next edge.
REQ-023 When sw_req and locked-low coincide, sw_req SHALL win.
REQ-024 rst_stage bits SHALL only deassert in RELEASE, in index order; assertion SHALL affect all bits simultaneously.
REQ-025 Stage and timeout counters SHALL be 16 bits and SHALL never wrap; each reloads on entering its state.
REQ-026 ACTIVE SHALL ignore init_done deassertion.

Reset
REQ-027 reset SHALL have priority over all inputs.
REQ-028 During reset: state=INIT, rst_stage all ones, init_start=0, ready=0, fault=0, counters zero.
REQ-029 reset mid-sequence SHALL abandon the sequence without further init_start pulses.

Configuration
REQ-030 Macro RST_SEQ_TIMEOUT_EN defined: INIT_WAIT SHALL count to INIT_TMO without init_done, then enter FAULT with fault=1 and all rst_stage asserted; FAULT exits only via sw_req or reset.
REQ-031 Macro RST_SEQ_TIMEOUT_EN undefined: INIT_WAIT SHALL wait indefinitely, FAULT SHALL be unreachable, and fault SHALL be tied 0.

Verification
REQ-032 NSTAGE=3, STAGE_DLY=4, LOCK_FILT=2; locked high from cycle 0 after reset -> rst_stage 111->110->100->000 at 4-cycle spacing; one init_start pulse; init_done high 5 cycles later -> ready=1 next cycle.
REQ-033 locked toggles high 1 cycle, low 1, then high steadily -> RELEASE entered only after 2 consecutive high cycles.
REQ-034 In ACTIVE, locked low 1 cycle -> rst_stage=111 and ready=0 next edge; state=LOCK_WAIT; full re-sequence follows.
REQ-035 TIMEOUT_EN defined, INIT_TMO=10, init_done held low -> FAULT after 10 cycles, fault=1; sw_req -> fault=0, state=INIT.
REQ-036 sw_req and locked-low on the same cycle during RELEASE -> state=INIT, not LOCK_WAIT.
REQ-037 reset asserted mid-RELEASE with rst_stage=110 -> rst_stage=111, state=0, no init_start pulse.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Ordered reset sequencer: lock filter, staged reset release, downstream init handshake.
// Optional init timeout / FAULT state enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int NSTAGE    = 3,
  parameter int STAGE_DLY = 1024,
  parameter int LOCK_FILT = 16,
  parameter int INIT_TMO  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              locked,
  input  logic              init_done,
  input  logic              sw_req,
  output logic [NSTAGE-1:0] rst_stage,
  output logic              init_start,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_LOCK_WAIT = 3'd1,
    S_RELEASE   = 3'd2,
    S_INIT_WAIT = 3'd3,
    S_ACTIVE    = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_FILT - 1);
  localparam logic [15:0] STG_LAST  = 16'(STAGE_DLY - 1);
  localparam logic [15:0] TMO_LAST  = 16'(INIT_TMO - 1);

  state_e            state_q, state_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [15:0]       stg_cnt_q, stg_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [NSTAGE-1:0] rst_q, rst_d;
  logic              init_start_q, init_start_d;

  logic [NSTAGE-1:0] rst_shift;
  logic              tmo_done;

  // Stages release from bit 0 upward, so shifting left drops the lowest asserted bit.
  assign rst_shift = rst_q << 1;
  assign tmo_done  = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      lock_cnt_q   <= '0;
      stg_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      rst_q        <= '1;
      init_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      stg_cnt_q    <= stg_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rst_q        <= rst_d;
      init_start_q <= init_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    stg_cnt_d    = stg_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    rst_d        = rst_q;
    init_start_d = 1'b0;

    if (sw_req && (state_q != S_INIT)) begin
      state_d    = S_INIT;
      rst_d      = '1;
      lock_cnt_d = '0;
      stg_cnt_d  = '0;
      tmo_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          state_d    = S_LOCK_WAIT;
          rst_d      = '1;
          lock_cnt_d = '0;
          stg_cnt_d  = '0;
          tmo_cnt_d  = '0;
        end
        S_LOCK_WAIT: begin
          if (!locked) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_d    = S_RELEASE;
            lock_cnt_d = '0;
            stg_cnt_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end
        S_RELEASE: begin
          if (!locked) begin
            state_d    = S_LOCK_WAIT;
            rst_d      = '1;
            lock_cnt_d = '0;
          end else if (stg_cnt_q == STG_LAST) begin
            stg_cnt_d = '0;
            rst_d     = rst_shift;
            if (rst_shift == '0) begin
              state_d      = S_INIT_WAIT;
              init_start_d = 1'b1;
              tmo_cnt_d    = '0;
            end
          end else begin
            stg_cnt_d = stg_cnt_q + 16'd1;
          end
        end
        S_INIT_WAIT: begin
          if (!locked) begin
            state_d    = S_LOCK_WAIT;
            rst_d      = '1;
            lock_cnt_d = '0;
          end else if (init_done) begin
            state_d = S_ACTIVE;
          end else if (!tmo_done) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end else begin
`ifdef RST_SEQ_TIMEOUT_EN
            state_d = S_FAULT;
            rst_d   = '1;
`else
            // Without the timeout the counter simply saturates and is ignored.
            tmo_cnt_d = tmo_cnt_q;
`endif
          end
        end
        S_ACTIVE: begin
          if (!locked) begin
            state_d    = S_LOCK_WAIT;
            rst_d      = '1;
            lock_cnt_d = '0;
          end
        end
        S_FAULT: begin
`ifdef RST_SEQ_TIMEOUT_EN
          rst_d = '1;
`else
          state_d = S_INIT;
          rst_d   = '1;
`endif
        end
        default: begin
          state_d = S_INIT;
          rst_d   = '1;
        end
      endcase
    end
  end

  // init_start is a one-cycle request; init_done is a level held by the downstream block.
  always_comb begin
    rst_stage  = rst_q;
    init_start = init_start_q;
    ready      = (state_q == S_ACTIVE);
`ifdef RST_SEQ_TIMEOUT_EN
    fault      = (state_q == S_FAULT);
`else
    fault      = 1'b0;
`endif
    state      = state_q;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NSTAGE=3, STAGE_DLY=4, LOCK_FILT=2, INIT_TMO=10.
// Timeout checks compile in only when RST_SEQ_TIMEOUT_EN is defined.
module tb_rst_seq_ctrl;

  localparam int NSTAGE = 3;

  logic              clk;
  logic              reset;
  logic              locked;
  logic              init_done;
  logic              sw_req;
  logic [NSTAGE-1:0] rst_stage;
  logic              init_start;
  logic              ready;
  logic              fault;
  logic [2:0]        state;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  logic [NSTAGE-1:0] exp_q[$];

  rst_seq_ctrl #(
    .NSTAGE   (NSTAGE),
    .STAGE_DLY(4),
    .LOCK_FILT(2),
    .INIT_TMO (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .init_done (init_done),
    .sw_req    (sw_req),
    .rst_stage (rst_stage),
    .init_start(init_start),
    .ready     (ready),
    .fault     (fault),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_start === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks RELEASE from entry through to INIT_WAIT entry.
  task automatic release_stages(input string tag);
    logic [NSTAGE-1:0] cur;
    cur = 3'b111;
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    for (int s = 0; s < NSTAGE; s++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check_eq({tag, "_hold"}, 32'(rst_stage), 32'(cur));
        check_eq({tag, "_nostart"}, 32'(init_start), 32'd0);
      end
      tick();
      cur = exp_q.pop_front();
      check_eq({tag, "_stage"}, 32'(rst_stage), 32'(cur));
    end
    check_eq({tag, "_st_initwait"}, 32'(state), 32'd3);
    check_eq({tag, "_init_start"}, 32'(init_start), 32'd1);
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; init_done = 1'b0; sw_req = 1'b0;
    repeat (3) tick();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_stage", 32'(rst_stage), 32'h7);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_start", 32'(init_start), 32'd0);

    // basic sequence
    reset = 1'b0; locked = 1'b1;
    tick(); check_eq("seq_lockwait", 32'(state), 32'd1);
    tick(); check_eq("seq_lockwait2", 32'(state), 32'd1);
    tick(); check_eq("seq_release", 32'(state), 32'd2);
    check_eq("seq_rel_rst", 32'(rst_stage), 32'h7);
    release_stages("seq");
    tick(); check_eq("seq_start_off", 32'(init_start), 32'd0);
    repeat (3) tick();
    check_eq("seq_notready", 32'(ready), 32'd0);
    init_done = 1'b1;
    tick(); check_eq("seq_active", 32'(state), 32'd4);
    check_eq("seq_ready", 32'(ready), 32'd1);
    init_done = 1'b0;
    tick(); check_eq("seq_ign_done", 32'(state), 32'd4);
    check_eq("seq_pulses", 32'(pulse_cnt), 32'd1);

    // lock loss in ACTIVE then re-sequence
    locked = 1'b0;
    tick(); check_eq("loss_state", 32'(state), 32'd1);
    check_eq("loss_rst", 32'(rst_stage), 32'h7);
    check_eq("loss_ready", 32'(ready), 32'd0);
    locked = 1'b1;
    tick(); check_eq("loss_lw", 32'(state), 32'd1);
    tick(); check_eq("loss_rel", 32'(state), 32'd2);
    release_stages("reseq");
    tick();
    init_done = 1'b1;
    tick(); check_eq("reseq_ready", 32'(ready), 32'd1);
    init_done = 1'b0;

    // software reset from ACTIVE, then glitchy lock filter
    sw_req = 1'b1;
    tick(); check_eq("sw_state", 32'(state), 32'd0);
    check_eq("sw_rst", 32'(rst_stage), 32'h7);
    check_eq("sw_ready", 32'(ready), 32'd0);
    sw_req = 1'b0; locked = 1'b0;
    tick(); check_eq("filt_lw", 32'(state), 32'd1);
    locked = 1'b1;
    tick(); check_eq("filt_one", 32'(state), 32'd1);
    locked = 1'b0;
    tick(); check_eq("filt_drop", 32'(state), 32'd1);
    locked = 1'b1;
    tick(); check_eq("filt_restart", 32'(state), 32'd1);
    tick(); check_eq("filt_release", 32'(state), 32'd2);

    // sw_req beats lock loss during RELEASE
    repeat (4) tick();
    check_eq("mix_stage", 32'(rst_stage), 32'h6);
    sw_req = 1'b1; locked = 1'b0;
    tick(); check_eq("mix_state", 32'(state), 32'd0);
    check_eq("mix_rst", 32'(rst_stage), 32'h7);
    sw_req = 1'b0; locked = 1'b1;

    // reset mid-RELEASE
    repeat (3) tick();
    check_eq("mr_release", 32'(state), 32'd2);
    repeat (4) tick();
    check_eq("mr_stage", 32'(rst_stage), 32'h6);
    reset = 1'b1;
    tick(); check_eq("mr_state", 32'(state), 32'd0);
    check_eq("mr_rst", 32'(rst_stage), 32'h7);
    tick();
    reset = 1'b0; locked = 1'b0;
    repeat (20) tick();
    check_eq("mr_lockwait", 32'(state), 32'd1);
    check_eq("mr_pulses", 32'(pulse_cnt), 32'd2);

    // INIT_WAIT with init_done held low
    locked = 1'b1;
    tick(); tick();
    check_eq("to_release", 32'(state), 32'd2);
    release_stages("to");
`ifdef RST_SEQ_TIMEOUT_EN
    repeat (9) tick();
    check_eq("to_wait", 32'(state), 32'd3);
    check_eq("to_nofault", 32'(fault), 32'd0);
    tick(); check_eq("to_fault_st", 32'(state), 32'd5);
    check_eq("to_fault", 32'(fault), 32'd1);
    check_eq("to_fault_rst", 32'(rst_stage), 32'h7);
    locked = 1'b0;
    repeat (3) tick();
    check_eq("to_fault_hold", 32'(state), 32'd5);
    sw_req = 1'b1;
    tick(); check_eq("to_sw_st", 32'(state), 32'd0);
    check_eq("to_sw_fault", 32'(fault), 32'd0);
    sw_req = 1'b0;
`else
    repeat (40) tick();
    check_eq("nto_wait", 32'(state), 32'd3);
    check_eq("nto_fault", 32'(fault), 32'd0);
`endif
    check_eq("to_pulses", 32'(pulse_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
